// File: rtl/slot_pkg.sv
// Shared slot-machine types: win classes, settlement states, default payout factors.
package slot_pkg;

  localparam int unsigned BCD_W            = 4;
  localparam int unsigned DEF_DIGITS       = 4;
  localparam int unsigned DEF_MULT_777     = 10;
  localparam int unsigned DEF_MULT_TRIPLE  = 5;
  localparam int unsigned DEF_MULT_PAIR    = 2;

  typedef enum logic [1:0] {
    WIN_LOSE   = 2'd0,
    WIN_PAIR   = 2'd1,
    WIN_TRIPLE = 2'd2,
    WIN_777    = 2'd3
  } win_class_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    ADD      = 2'd2,
    WRITE    = 2'd3
  } settle_state_e;

  typedef struct packed {
    logic [BCD_W-1:0] r1;
    logic [BCD_W-1:0] r2;
    logic [BCD_W-1:0] r3;
  } reels_t;

  // Non-BCD digits on any reel always lose.
  function automatic win_class_e classify_reels(input reels_t r);
    logic bad, e12, e13, e23;
    bad = (r.r1 > 4'd9) || (r.r2 > 4'd9) || (r.r3 > 4'd9);
    e12 = (r.r1 == r.r2);
    e13 = (r.r1 == r.r3);
    e23 = (r.r2 == r.r3);
    if (bad)                           return WIN_LOSE;
    else if (e12 && e13 && r.r1 == 4'd7) return WIN_777;
    else if (e12 && e13)               return WIN_TRIPLE;
    else if (e12 || e13 || e23)        return WIN_PAIR;
    else                               return WIN_LOSE;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with carry in/out.
module bcd_digit_add
  import slot_pkg::*;
(
  input  logic [BCD_W-1:0] a_i,
  input  logic [BCD_W-1:0] b_i,
  input  logic             ci_i,
  output logic [BCD_W-1:0] sum_c_o,
  output logic             co_c_o
);

  logic [BCD_W:0] raw;

  always_comb begin
    raw     = (BCD_W+1)'(a_i) + (BCD_W+1)'(b_i) + (BCD_W+1)'(ci_i);
    sum_c_o = raw[BCD_W-1:0];
    co_c_o  = 1'b0;
    if (raw > (BCD_W+1)'(9)) begin
      sum_c_o = BCD_W'(raw - (BCD_W+1)'(10));
      co_c_o  = 1'b1;
    end
  end

endmodule

// File: rtl/slot_payout.sv
// Settlement engine: classifies stopped reels and credits stake*factor to the
// balance by repeated digit-serial BCD addition, then writes back and clears stake.
module slot_payout
  import slot_pkg::*;
#(
  parameter int unsigned DIGITS      = DEF_DIGITS,
  parameter int unsigned MULT_777    = DEF_MULT_777,
  parameter int unsigned MULT_TRIPLE = DEF_MULT_TRIPLE,
  parameter int unsigned MULT_PAIR   = DEF_MULT_PAIR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    settle,
  input  logic [BCD_W-1:0]        reel1,
  input  logic [BCD_W-1:0]        reel2,
  input  logic [BCD_W-1:0]        reel3,
  input  logic [BCD_W*DIGITS-1:0] stake_bcd,
  input  logic [BCD_W*DIGITS-1:0] balance_bcd,
  output logic [BCD_W*DIGITS-1:0] balance_out,
  output logic                    balance_we,
  output logic                    stake_clr,
  output logic                    busy,
  output logic [1:0]              win_class,
  output logic                    saturated
);

  localparam int unsigned W     = BCD_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned REP_W = 8;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  settle_state_e    state_q, state_d;
  reels_t           reels_q, reels_d;
  logic [W-1:0]     stake_q, stake_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     bal_out_q, bal_out_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [REP_W-1:0] rep_q, rep_d;
  win_class_e       class_q, class_d;
  logic             sat_q, sat_d;
  logic             we_q, we_d;
  logic             clr_q, clr_d;
  logic             busy_q, busy_d;

  win_class_e       cls_c;
  logic [REP_W-1:0] rep_cls_c;
  logic [BCD_W-1:0] sum_c;
  logic             co_c;
  logic             last_c;

  // Acc and stake rotate right one digit per cycle, so digit 0 is always at the adder.
  bcd_digit_add u_add (
    .a_i     (acc_q[BCD_W-1:0]),
    .b_i     (stake_q[BCD_W-1:0]),
    .ci_i    (carry_q),
    .sum_c_o (sum_c),
    .co_c_o  (co_c)
  );

  assign cls_c  = classify_reels(reels_q);
  assign last_c = (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    rep_cls_c = '0;
    case (cls_c)
      WIN_777:    rep_cls_c = REP_W'(MULT_777);
      WIN_TRIPLE: rep_cls_c = REP_W'(MULT_TRIPLE);
      WIN_PAIR:   rep_cls_c = REP_W'(MULT_PAIR);
      default:    rep_cls_c = '0;
    endcase
  end

  // State register and datapath/output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      reels_q   <= '0;
      stake_q   <= '0;
      acc_q     <= '0;
      bal_out_q <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      rep_q     <= '0;
      class_q   <= WIN_LOSE;
      sat_q     <= 1'b0;
      we_q      <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      reels_q   <= reels_d;
      stake_q   <= stake_d;
      acc_q     <= acc_d;
      bal_out_q <= bal_out_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      rep_q     <= rep_d;
      class_q   <= class_d;
      sat_q     <= sat_d;
      we_q      <= we_d;
      clr_q     <= clr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (settle) state_d = CLASSIFY;
      CLASSIFY: state_d = (rep_cls_c == '0 || stake_q == '0) ? WRITE : ADD;
      ADD:      if (last_c && (co_c || rep_q == REP_W'(1))) state_d = WRITE;
      WRITE:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs, aligned so strobes are high in the WRITE cycle.
  always_comb begin
    reels_d   = reels_q;
    stake_d   = stake_q;
    acc_d     = acc_q;
    bal_out_d = bal_out_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    rep_d     = rep_q;
    class_d   = class_q;
    sat_d     = sat_q;
    we_d      = 1'b0;
    clr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (settle) begin
          reels_d = '{r1: reel1, r2: reel2, r3: reel3};
          stake_d = stake_bcd;
          acc_d   = balance_bcd;
        end
      end
      CLASSIFY: begin
        class_d = cls_c;
        sat_d   = 1'b0;
        rep_d   = rep_cls_c;
        idx_d   = '0;
        carry_d = 1'b0;
      end
      ADD: begin
        acc_d   = (acc_q >> BCD_W) | (W'(sum_c) << (W - BCD_W));
        stake_d = (stake_q >> BCD_W) | (W'(stake_q[BCD_W-1:0]) << (W - BCD_W));
        carry_d = co_c;
        idx_d   = idx_q + IDX_W'(1);
        if (last_c) begin
          idx_d   = '0;
          carry_d = 1'b0;
          if (co_c) begin
            acc_d = ALL_NINES;
            sat_d = 1'b1;
          end else begin
            rep_d = rep_q - REP_W'(1);
          end
        end
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
    if (state_d == WRITE) begin
      we_d      = 1'b1;
      clr_d     = 1'b1;
      bal_out_d = acc_d;
    end
  end

  assign balance_out = bal_out_q;
  assign balance_we  = we_q;
  assign stake_clr   = clr_q;
  assign busy        = busy_q;
  assign win_class   = class_q;
  assign saturated   = sat_q;

endmodule

// File: tb/tb_slot_payout.sv
// Directed bench for slot_payout: win classes, latency, saturation, settle/reset robustness.
module tb_slot_payout;

  logic        clk = 1'b0;
  logic        reset;
  logic        settle;
  logic [3:0]  reel1, reel2, reel3;
  logic [15:0] stake_bcd, balance_bcd;
  logic [15:0] balance_out;
  logic        balance_we, stake_clr, busy, saturated;
  logic [1:0]  win_class;

  int n_checks = 0;
  int n_pass   = 0;

  slot_payout dut (
    .clk         (clk),
    .reset       (reset),
    .settle      (settle),
    .reel1       (reel1),
    .reel2       (reel2),
    .reel3       (reel3),
    .stake_bcd   (stake_bcd),
    .balance_bcd (balance_bcd),
    .balance_out (balance_out),
    .balance_we  (balance_we),
    .stake_clr   (stake_clr),
    .busy        (busy),
    .win_class   (win_class),
    .saturated   (saturated)
  );

  always #5 clk = ~clk;

  // Pulses settle, scrambles inputs afterwards, waits (bounded) for the write strobe.
  task automatic do_settle(input logic [15:0] bal, input logic [15:0] stk,
                           input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3,
                           output int lat, output logic [15:0] bo, output logic clr,
                           output logic [1:0] wc, output logic sat, output logic busy_ok);
    @(negedge clk);
    balance_bcd = bal; stake_bcd = stk;
    reel1 = r1; reel2 = r2; reel3 = r3;
    settle = 1'b1;
    @(negedge clk);
    settle = 1'b0;
    balance_bcd = 16'h9999; stake_bcd = 16'h9999;
    reel1 = 4'd7; reel2 = 4'd7; reel3 = 4'd7;
    lat = 1;
    busy_ok = 1'b1;
    while (balance_we !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    bo = balance_out; clr = stake_clr; wc = win_class; sat = saturated;
  endtask

  task automatic test_reset();
    reset = 1'b0; settle = 1'b0;
    reel1 = '0; reel2 = '0; reel3 = '0; stake_bcd = '0; balance_bcd = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({balance_out, balance_we, stake_clr, busy, win_class, saturated} !== 22'd0)
      $display("FAIL reset_outputs got out=%h we=%b clr=%b busy=%b wc=%0d sat=%b exp all zero",
               balance_out, balance_we, stake_clr, busy, win_class, saturated);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_777();
    int lat; logic [15:0] bo; logic clr, sat, bok; logic [1:0] wc;
    do_settle(16'h4990, 16'h0010, 4'd7, 4'd7, 4'd7, lat, bo, clr, wc, sat, bok);
    n_checks++; if (lat !== 42) $display("FAIL 777_latency got %0d exp 42", lat); else n_pass++;
    n_checks++; if (bo !== 16'h5090) $display("FAIL 777_balance got %h exp 5090", bo); else n_pass++;
    n_checks++; if (clr !== 1'b1) $display("FAIL 777_stake_clr got %b exp 1", clr); else n_pass++;
    n_checks++; if (wc !== 2'd3) $display("FAIL 777_class got %0d exp 3", wc); else n_pass++;
    n_checks++; if (sat !== 1'b0) $display("FAIL 777_saturated got %b exp 0", sat); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("FAIL 777_busy got %b exp 1 throughout", bok); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (balance_we !== 1'b0 || stake_clr !== 1'b0 || busy !== 1'b0)
      $display("FAIL 777_after_write got we=%b clr=%b busy=%b exp 0 0 0", balance_we, stake_clr, busy);
    else n_pass++;
    n_checks++; if (balance_out !== 16'h5090) $display("FAIL 777_hold got %h exp 5090", balance_out); else n_pass++;
    n_checks++; if (win_class !== 2'd3) $display("FAIL 777_class_hold got %0d exp 3", win_class); else n_pass++;
  endtask

  task automatic test_saturate();
    int lat; logic [15:0] bo; logic clr, sat, bok; logic [1:0] wc;
    do_settle(16'h9950, 16'h0100, 4'd7, 4'd7, 4'd7, lat, bo, clr, wc, sat, bok);
    n_checks++; if (lat !== 6) $display("FAIL sat_latency got %0d exp 6", lat); else n_pass++;
    n_checks++; if (bo !== 16'h9999) $display("FAIL sat_balance got %h exp 9999", bo); else n_pass++;
    n_checks++; if (sat !== 1'b1) $display("FAIL sat_flag got %b exp 1", sat); else n_pass++;
    n_checks++; if (clr !== 1'b1) $display("FAIL sat_stake_clr got %b exp 1", clr); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (saturated !== 1'b1) $display("FAIL sat_hold got %b exp 1", saturated); else n_pass++;
  endtask

  task automatic test_triple();
    int lat; logic [15:0] bo; logic clr, sat, bok; logic [1:0] wc;
    do_settle(16'h0000, 16'h0020, 4'd3, 4'd3, 4'd3, lat, bo, clr, wc, sat, bok);
    n_checks++; if (lat !== 22) $display("FAIL triple_latency got %0d exp 22", lat); else n_pass++;
    n_checks++; if (bo !== 16'h0100) $display("FAIL triple_balance got %h exp 0100", bo); else n_pass++;
    n_checks++; if (wc !== 2'd2) $display("FAIL triple_class got %0d exp 2", wc); else n_pass++;
    n_checks++; if (sat !== 1'b0) $display("FAIL triple_sat_cleared got %b exp 0", sat); else n_pass++;
  endtask

  task automatic test_pair();
    int lat; logic [15:0] bo; logic clr, sat, bok; logic [1:0] wc;
    do_settle(16'h1234, 16'h0010, 4'd1, 4'd2, 4'd1, lat, bo, clr, wc, sat, bok);
    n_checks++; if (lat !== 10) $display("FAIL pair_latency got %0d exp 10", lat); else n_pass++;
    n_checks++; if (bo !== 16'h1254) $display("FAIL pair_balance got %h exp 1254", bo); else n_pass++;
    n_checks++; if (wc !== 2'd1) $display("FAIL pair_class got %0d exp 1", wc); else n_pass++;
    // Pair formed by reels 2 and 3, with a digit carry chain: 0995 + 2*0005.
    do_settle(16'h0995, 16'h0005, 4'd4, 4'd9, 4'd9, lat, bo, clr, wc, sat, bok);
    n_checks++; if (bo !== 16'h1005) $display("FAIL pair23_balance got %h exp 1005", bo); else n_pass++;
    n_checks++; if (wc !== 2'd1) $display("FAIL pair23_class got %0d exp 1", wc); else n_pass++;
  endtask

  task automatic test_lose();
    int lat; logic [15:0] bo; logic clr, sat, bok; logic [1:0] wc;
    do_settle(16'h1234, 16'h0050, 4'd1, 4'd2, 4'd3, lat, bo, clr, wc, sat, bok);
    n_checks++; if (lat !== 2) $display("FAIL lose_latency got %0d exp 2", lat); else n_pass++;
    n_checks++; if (bo !== 16'h1234) $display("FAIL lose_balance got %h exp 1234", bo); else n_pass++;
    n_checks++; if (clr !== 1'b1) $display("FAIL lose_stake_clr got %b exp 1", clr); else n_pass++;
    n_checks++; if (wc !== 2'd0) $display("FAIL lose_class got %0d exp 0", wc); else n_pass++;
  endtask

  task automatic test_bad_digit_and_zero_stake();
    int lat; logic [15:0] bo; logic clr, sat, bok; logic [1:0] wc;
    do_settle(16'h0042, 16'h0100, 4'hA, 4'hA, 4'hA, lat, bo, clr, wc, sat, bok);
    n_checks++; if (wc !== 2'd0) $display("FAIL bad_digit_class got %0d exp 0", wc); else n_pass++;
    n_checks++; if (lat !== 2 || bo !== 16'h0042)
      $display("FAIL bad_digit_write got lat=%0d bal=%h exp lat=2 bal=0042", lat, bo); else n_pass++;
    do_settle(16'h0777, 16'h0000, 4'd7, 4'd7, 4'd7, lat, bo, clr, wc, sat, bok);
    n_checks++; if (lat !== 2 || bo !== 16'h0777 || wc !== 2'd3)
      $display("FAIL zero_stake got lat=%0d bal=%h wc=%0d exp lat=2 bal=0777 wc=3", lat, bo, wc);
    else n_pass++;
  endtask

  task automatic test_settle_ignored();
    int lat;
    @(negedge clk);
    balance_bcd = 16'h1234; stake_bcd = 16'h0010;
    reel1 = 4'd1; reel2 = 4'd2; reel3 = 4'd1; settle = 1'b1;
    @(negedge clk);
    settle = 1'b0;
    lat = 1;
    while (balance_we !== 1'b1 && lat < 100) begin
      if (lat == 3 || lat == 7) begin
        balance_bcd = 16'h0000; stake_bcd = 16'h0500;
        reel1 = 4'd7; reel2 = 4'd7; reel3 = 4'd7; settle = 1'b1;
      end else settle = 1'b0;
      @(negedge clk);
      lat++;
    end
    settle = 1'b0;
    n_checks++;
    if (lat !== 10 || balance_out !== 16'h1254 || win_class !== 2'd1)
      $display("FAIL settle_ignored got lat=%0d bal=%h wc=%0d exp lat=10 bal=1254 wc=1",
               lat, balance_out, win_class);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL settle_ignored_idle got busy=%b exp 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_add();
    logic strobe_seen;
    @(negedge clk);
    balance_bcd = 16'h4990; stake_bcd = 16'h0010;
    reel1 = 4'd7; reel2 = 4'd7; reel3 = 4'd7; settle = 1'b1;
    @(negedge clk);
    settle = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_add_busy got %b exp 1", busy); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({balance_out, balance_we, stake_clr, busy, win_class, saturated} !== 22'd0)
      $display("FAIL mid_add_reset got out=%h we=%b clr=%b busy=%b wc=%0d sat=%b exp all zero",
               balance_out, balance_we, stake_clr, busy, win_class, saturated);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    strobe_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (balance_we !== 1'b0 || stake_clr !== 1'b0 || busy !== 1'b0) strobe_seen = 1'b1;
    end
    n_checks++;
    if (strobe_seen !== 1'b0) $display("FAIL mid_add_no_write got activity=%b exp 0", strobe_seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_777();
    test_saturate();
    test_triple();
    test_pair();
    test_lose();
    test_bad_digit_and_zero_stake();
    test_settle_ignored();
    test_reset_mid_add();
    test_lose();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
